// File: rtl/prio_enc_reg.sv
// Registered N-input priority encoder with a one-entry valid/ready output stage.
// MODE 0 picks the highest set index; MODE 1 round-robins from a rotating pointer.
module prio_enc_reg #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_idx;
  logic         r_multi;

  logic         w_load;
  logic         w_any;
  logic         w_multi;
  logic [W-1:0] w_win;

  assign w_load  = (r_state == S_EMPTY) || out_ready;
  assign w_any   = |req;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(req & (req - N'(1)));

  generate
    if (MODE == 1) begin : g_rr
      logic [W-1:0] r_ptr;
      logic [W-1:0] w_lo_idx;
      logic [W-1:0] w_hi_idx;
      logic         w_lo_found;

      // Search order ptr..0 then N-1..ptr+1 equals: highest set bit at or below
      // ptr if any, otherwise the highest set bit overall.
      always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            w_hi_idx = W'(i);
            if (i <= int'(r_ptr)) begin
              w_lo_found = 1'b1;
              w_lo_idx   = W'(i);
            end
          end
        end
      end

      assign w_win = w_lo_found ? w_lo_idx : w_hi_idx;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ptr <= W'(N - 1);
        end else if (w_load && w_any) begin
          r_ptr <= (w_win == '0) ? W'(N - 1) : w_win - W'(1);
        end
      end
    end else begin : g_fixed
      logic [W-1:0] w_hi_idx;

      always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) w_hi_idx = W'(i);
        end
      end

      assign w_win = w_hi_idx;
    end
  endgenerate

  // Index and multi flag are left untouched on an empty load; they are don't-care while invalid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_EMPTY;
      r_idx   <= '0;
      r_multi <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_state <= S_FULL;
        r_idx   <= w_win;
        r_multi <= w_multi;
      end else begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_idx   = r_idx;
  assign out_multi = r_multi;

endmodule

// File: tb/tb_prio_enc_reg.sv
// Directed self-checking bench for prio_enc_reg: fixed priority (N=8), round-robin
// (N=8) and round-robin with a non-power-of-two width (N=5), sharing clock and reset.
module tb_prio_enc_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req0, req1;
  logic [4:0] req5;
  logic       rdy0, rdy1, rdy5;
  logic       v0, v1, v5;
  logic [2:0] idx0, idx1, idx5;
  logic       m0, m1, m5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prio_enc_reg #(.N(8), .MODE(0)) u_fixed (
    .clk(clk), .rst(rst), .req(req0), .out_ready(rdy0),
    .out_valid(v0), .out_idx(idx0), .out_multi(m0)
  );

  prio_enc_reg #(.N(8), .MODE(1)) u_rr8 (
    .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1),
    .out_valid(v1), .out_idx(idx1), .out_multi(m1)
  );

  prio_enc_reg #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .req(req5), .out_ready(rdy5),
    .out_valid(v5), .out_idx(idx5), .out_multi(m5)
  );

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_multi;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rr8_seq[10];
    int rr5_seq[7];
    int alt_seq[4];

    rst  = 1'b1;
    req0 = '0; req1 = '0; req5 = '0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy5 = 1'b0;

    tbl[0] = '{8'd127,       1'b1, 1'b1, 3'd6, 1'b1};
    tbl[1] = '{8'd64,        1'b1, 1'b1, 3'd6, 1'b0};
    tbl[2] = '{8'd1,         1'b1, 1'b1, 3'd0, 1'b0};
    tbl[3] = '{8'b11000000,  1'b1, 1'b1, 3'd7, 1'b1};
    tbl[4] = '{8'b00001010,  1'b1, 1'b1, 3'd3, 1'b1};
    tbl[5] = '{8'd0,         1'b1, 1'b0, 3'd3, 1'b1};
    rr8_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    rr5_seq = '{4, 3, 2, 1, 0, 4, 3};
    alt_seq = '{5, 2, 5, 2};

    tick();
    tick();
    rst = 1'b0;

    // Reset state on all instances
    check("rst_valid_fixed", v0, 0);
    check("rst_idx_fixed",   idx0, 0);
    check("rst_multi_fixed", m0, 0);
    check("rst_valid_rr8",   v1, 0);
    check("rst_idx_rr8",     idx1, 0);
    check("rst_valid_rr5",   v5, 0);

    // Fixed priority table
    for (int i = 0; i < 6; i++) begin
      req0 = tbl[i].req;
      rdy0 = tbl[i].rdy;
      tick();
      check($sformatf("fixed_valid[%0d]", i), v0, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check($sformatf("fixed_idx[%0d]", i),   idx0, tbl[i].exp_idx);
        check($sformatf("fixed_multi[%0d]", i), m0,   tbl[i].exp_multi);
      end
    end

    // Backpressure: held result ignores changing req
    rdy0 = 1'b0;
    req0 = 8'b00100000;
    tick();
    check("bp_first_valid", v0, 1);
    check("bp_first_idx",   idx0, 5);
    req0 = 8'b00000010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid[%0d]", i), v0, 1);
      check($sformatf("bp_hold_idx[%0d]", i),   idx0, 5);
    end
    rdy0 = 1'b1;
    tick();
    check("bp_release_valid", v0, 1);
    check("bp_release_idx",   idx0, 1);
    req0 = '0;
    tick();
    check("bp_drain_valid", v0, 0);

    // Round-robin fairness with all requests
    do_reset();
    req1 = 8'hFF;
    rdy1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rr8_fair_idx[%0d]", i), idx1, rr8_seq[i]);
      check($sformatf("rr8_fair_valid[%0d]", i), v1, 1);
    end

    // Round-robin alternation, then ready toggling must not move the pointer on holds
    do_reset();
    req1 = 8'b00100100;
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr8_alt_idx[%0d]", i), idx1, alt_seq[i]);
    end
    rdy1 = 1'b0; tick(); check("rr8_tog_hold0", idx1, 2);
    rdy1 = 1'b1; tick(); check("rr8_tog_load0", idx1, 5);
    rdy1 = 1'b0; tick(); check("rr8_tog_hold1", idx1, 5);
    tick();              check("rr8_tog_hold2", idx1, 5);
    rdy1 = 1'b1; tick(); check("rr8_tog_load1", idx1, 2);
    tick();              check("rr8_tog_load2", idx1, 5);
    req1 = '0;   tick(); check("rr8_tog_drain", v1, 0);

    // Non-power-of-two wrap
    do_reset();
    req5 = 5'b11111;
    rdy5 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("rr5_idx[%0d]", i), idx5, rr5_seq[i]);
      check($sformatf("rr5_multi[%0d]", i), m5, 1);
    end

    // Reset in the middle of a hold discards the result and restores the pointer
    do_reset();
    req1 = 8'hFF;
    rdy1 = 1'b1;
    tick(); tick(); tick();
    check("rsthold_pre_idx", idx1, 5);
    rdy1 = 1'b0;
    tick();
    check("rsthold_hold_valid", v1, 1);
    check("rsthold_hold_multi", m1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsthold_valid", v1, 0);
    check("rsthold_idx",   idx1, 0);
    check("rsthold_multi", m1, 0);
    rdy1 = 1'b1;
    tick();
    check("rsthold_next_valid", v1, 1);
    check("rsthold_next_idx",   idx1, 7);

    // Reset wins over a same-cycle load
    req0 = 8'h81;
    rdy0 = 1'b1;
    tick();
    check("rstload_pre_valid", v0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstload_valid", v0, 0);
    check("rstload_idx",   idx0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_reg.md
# prio_enc_reg

Parametrised, registered N-input priority encoder with valid/ready output handshake and selectable fixed-priority or round-robin mode. It is the clocked successor to the team's combinational 8:3 priority encoder. It sits between a bank of request lines and a single consumer. Each accepted encode is presented as a held index until the consumer takes it.

## Interface
- `N`, default 8: number of request inputs; legal range 2..256; need not be a power of two.
- `W`, default `$clog2(N)`: index width; must not be overridden independently of `N`.
- `MODE`, default 0: 0 = fixed priority, highest index wins; 1 = round-robin.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: request vector; sampled only on load cycles.
- `out_ready`, input, 1: consumer accepts the current result.
- `out_valid`, output, 1: `out_idx` and `out_multi` hold a result.
- `out_idx`, output, W: encoded winning request index.
- `out_multi`, output, 1: more than one `req` bit was set when the result was captured.

## Operation
- **Load enable:** `load = !out_valid || out_ready`. This is a one-entry output register with full throughput.
- **Load with request:** on a rising edge with `load`=1 and `req` != 0:
  - `out_valid` <= 1.
  - `out_idx` <= winner.
  - `out_multi` <= (popcount(req) > 1).
- **Load without request:** on a rising edge with `load`=1 and `req` == 0:
  - `out_valid` <= 0.
  - `out_idx` and `out_multi` keep their previous values; they are don't-care while invalid.
- **Hold:** while `out_valid`=1 and `out_ready`=0, `out_idx` and `out_multi` stay stable. `req` is ignored, even if the winning bit drops.
- **MODE 0 winner:** the highest set index of `req`.
- **MODE 1 pointer:** internal `ptr` is W bits, range 0..N-1.
  - Search order is `ptr`, `ptr`-1, …, 0, N-1, …, `ptr`+1; the first set bit wins.
  - On each load with `req` != 0, `ptr` <= (winner == 0) ? N-1 : winner-1. The just-granted index therefore becomes lowest priority.
  - `ptr` never takes values ≥ N; wrap is modulo N, not modulo 2^W.
  - `ptr` does not change on loads with `req`=0 or on hold cycles.
- **MODE 0 pointer:** no pointer exists; the logic is absent.
- **Two-state FSM:**
  - EMPTY (`out_valid`=0) → FULL on a load with `req` != 0.
  - FULL → EMPTY on `out_ready`=1 with `req`=0.
  - FULL → FULL on `out_ready`=1 with `req` != 0 (back-to-back), or on `out_ready`=0 (hold).
- **Input values:** `req` bits are 0/1 only. X/Z on `req` is not a supported stimulus and produces no defined output.

## Timing
- **Latency:** 1 cycle. `req` sampled at edge k appears on the outputs after edge k.
- **Throughput:** one result per cycle with `out_ready` held at 1.
- **Combinational paths:** no combinational path from `req` or `out_ready` to any output.
- **Reset values:** `out_valid`=0, `out_idx`=0, `out_multi`=0, `ptr`=N-1. With `ptr`=N-1, the first MODE 1 decision equals the MODE 0 decision.
- **Reset priority:** reset overrides load and handshake in the same cycle. A result pending at reset is discarded; it does not count as consumed and does not update `ptr`.
- **Handshake with ready:** a transfer occurs on an edge where `out_valid`=1 and `out_ready`=1. The next result, if any, replaces it on that same edge.
- **Ready while empty:** `out_ready` is don't-care while `out_valid`=0.

## Test plan
- **MODE 0 priority:** hold `out_ready`=1 and drive `req` = 8'd127, 8'd64, 8'd1, 8'b11000000, 8'b00001010, 0 on successive cycles.
  - `out_idx` = 6, 6, 0, 7, 3, each one cycle later.
  - `out_multi` = 1, 0, 0, 1, 1.
  - `out_valid` drops to 0 after the `req`=0 cycle.
- **Backpressure:** drive `req`=8'b00100000 with `out_ready`=0, then change `req` to 8'b00000010 for 5 cycles.
  - `out_idx` stays at 5 with `out_valid`=1 throughout.
  - Raising `out_ready` completes the transfer; `out_idx`=1 follows on the next cycle.
- **MODE 1 fairness:** hold `req`=8'hFF and `out_ready`=1 from reset.
  - Grant sequence 7,6,5,4,3,2,1,0,7,…, one per cycle.
- **MODE 1 alternation:** hold `req`=8'b00100100 and `out_ready`=1.
  - Grants alternate 5,2,5,2.
  - With `out_ready` toggling, `ptr` advances only on loads.
- **Non-power-of-two wrap:** set N=5, MODE=1, `req`=5'b11111.
  - Grants 4,3,2,1,0,4; `out_idx` never exceeds 4.
- **Reset mid-hold:** while `out_valid`=1 and `out_ready`=0, assert `rst` for one cycle.
  - Next cycle: `out_valid`=0, `out_idx`=0, `out_multi`=0.
  - The next MODE 1 grant with `req`=8'hFF is 7.
